// File: rtl/id_ex_ctrl_pipe.sv
// ID/EX control pipeline for RV32I(+M): decodes in ID, registers the control bundle into EX with
// a valid/ready handshake, load-use bubble, multi-cycle MUL/DIV hold, flush and illegal flag.
module id_ex_ctrl_pipe #(
  parameter bit          HAS_MULDIV = 1'b1,
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned REG_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [6:0]       id_opcode,
  input  logic [2:0]       id_funct3,
  input  logic [6:0]       id_funct7,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [REG_W-1:0] ex_rd,
  output logic [3:0]       ALUControl,
  output logic             ALUSourceA,
  output logic [1:0]       ALUSourceB,
  output logic             Dmem1ALUOUT,
  output logic             DmemREB,
  output logic             DmemWEB,
  output logic             LoadStoremuxsel,
  output logic             mux2sel,
  output logic             ex_illegal,
  output logic             muldiv_busy
);

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;
  localparam logic [6:0] F7Base   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;
  localparam logic [6:0] F7MulDiv = 7'b0000001;

  localparam logic [3:0] AluAnd  = 4'b0000;
  localparam logic [3:0] AluOr   = 4'b0001;
  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluSltu = 4'b0011;
  localparam logic [3:0] AluXor  = 4'b0100;
  localparam logic [3:0] AluSll  = 4'b0101;
  localparam logic [3:0] AluSub  = 4'b0110;
  localparam logic [3:0] AluSlt  = 4'b0111;
  localparam logic [3:0] AluSrl  = 4'b1000;
  localparam logic [3:0] AluSra  = 4'b1001;
  localparam logic [3:0] AluMul  = 4'b1010;
  localparam logic [3:0] AluDiv  = 4'b1011;
  localparam logic [3:0] AluRem  = 4'b1100;

  localparam logic [3:0] CntInit = 4'(MULDIV_LAT - 1);

  typedef struct packed {
    logic [3:0]       alu;
    logic [1:0]       srcb;
    logic             d1;
    logic             reb;
    logic             web;
    logic             lsm;
    logic             ill;
    logic [REG_W-1:0] rd;
  } bundle_t;

  localparam bundle_t NopBundle = '{alu: AluAdd, srcb: 2'b00, d1: 1'b0, reb: 1'b1, web: 1'b1,
                                    lsm: 1'b0, ill: 1'b0, rd: '0};

  bundle_t    r_bundle, w_bundle_d, w_dec;
  logic       r_valid, w_valid_d;
  logic       r_busy, w_busy_d;
  logic [3:0] r_cnt, w_cnt_d;
  logic       w_legal, w_md, w_reads_rs2, w_stall, w_capture;

  always_comb begin
    w_dec   = NopBundle;
    w_legal = 1'b0;
    w_md    = 1'b0;
    case (id_opcode)
      OpcOp: begin
        w_legal = 1'b1;
        if (id_funct7 == F7Base) begin
          case (id_funct3)
            3'b000:  w_dec.alu = AluAdd;
            3'b001:  w_dec.alu = AluSll;
            3'b010:  w_dec.alu = AluSlt;
            3'b011:  w_dec.alu = AluSltu;
            3'b100:  w_dec.alu = AluXor;
            3'b101:  w_dec.alu = AluSrl;
            3'b110:  w_dec.alu = AluOr;
            default: w_dec.alu = AluAnd;
          endcase
        end else if (id_funct7 == F7Alt && id_funct3 == 3'b000) begin
          w_dec.alu = AluSub;
        end else if (id_funct7 == F7Alt && id_funct3 == 3'b101) begin
          w_dec.alu = AluSra;
        end else if (HAS_MULDIV && id_funct7 == F7MulDiv) begin
          // MUL* share one code, DIV/DIVU and REM/REMU likewise
          w_md = 1'b1;
          if (!id_funct3[2])      w_dec.alu = AluMul;
          else if (!id_funct3[1]) w_dec.alu = AluDiv;
          else                    w_dec.alu = AluRem;
        end else begin
          w_legal = 1'b0;
        end
      end
      OpcOpImm: begin
        w_legal      = 1'b1;
        w_dec.srcb   = 2'b10;
        case (id_funct3)
          3'b000:  w_dec.alu = AluAdd;
          3'b010:  w_dec.alu = AluSlt;
          3'b011:  w_dec.alu = AluSltu;
          3'b100:  w_dec.alu = AluXor;
          3'b110:  w_dec.alu = AluOr;
          3'b111:  w_dec.alu = AluAnd;
          3'b001: begin
            w_dec.alu = AluSll;
            w_legal   = (id_funct7 == F7Base);
          end
          default: begin
            w_dec.alu = (id_funct7 == F7Alt) ? AluSra : AluSrl;
            w_legal   = (id_funct7 == F7Base) || (id_funct7 == F7Alt);
          end
        endcase
      end
      OpcLoad: begin
        if (id_funct3 == 3'b010) begin
          w_legal     = 1'b1;
          w_dec.srcb  = 2'b11;
          w_dec.d1    = 1'b1;
          w_dec.reb   = 1'b0;
        end
      end
      OpcStore: begin
        if (id_funct3 == 3'b010) begin
          w_legal     = 1'b1;
          w_dec.srcb  = 2'b11;
          w_dec.d1    = 1'b1;
          w_dec.web   = 1'b0;
          w_dec.lsm   = 1'b1;
        end
      end
      default: ;
    endcase
    if (w_legal) begin
      w_dec.rd = id_rd;
    end else begin
      // Illegal ops travel as a flagged NOP with rd=x0 so nothing is written back
      w_dec     = NopBundle;
      w_dec.ill = 1'b1;
      w_md      = 1'b0;
    end
  end

  assign w_reads_rs2 = (id_opcode == OpcOp) || (id_opcode == OpcStore);
  assign w_stall     = r_valid && !r_bundle.reb && (r_bundle.rd != '0) &&
                       ((r_bundle.rd == id_rs1) || (w_reads_rs2 && (r_bundle.rd == id_rs2)));
  assign id_ready    = !w_stall && (!(r_valid || r_busy) || (r_valid && ex_ready));
  assign w_capture   = id_valid && id_ready && !flush;

  always_comb begin
    w_bundle_d = r_bundle;
    w_valid_d  = r_valid;
    w_busy_d   = r_busy;
    w_cnt_d    = r_cnt;
    if (flush) begin
      w_bundle_d = NopBundle;
      w_valid_d  = 1'b0;
      w_busy_d   = 1'b0;
      w_cnt_d    = '0;
    end else if (w_capture) begin
      w_bundle_d = w_dec;
      w_valid_d  = !w_md;
      w_busy_d   = w_md;
      w_cnt_d    = w_md ? CntInit : 4'd0;
    end else if (r_busy) begin
      w_cnt_d = r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        w_busy_d  = 1'b0;
        w_valid_d = 1'b1;
      end
    end else if (r_valid && ex_ready) begin
      // Drained with nothing behind it: EX becomes a bubble
      w_bundle_d = NopBundle;
      w_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bundle <= NopBundle;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_bundle <= w_bundle_d;
      r_valid  <= w_valid_d;
      r_busy   <= w_busy_d;
      r_cnt    <= w_cnt_d;
    end
  end

  assign ex_valid        = r_valid;
  assign muldiv_busy     = r_busy;
  assign ex_rd           = r_bundle.rd;
  assign ALUControl      = r_bundle.alu;
  assign ALUSourceA      = 1'b0;
  assign ALUSourceB      = r_bundle.srcb;
  assign Dmem1ALUOUT     = r_bundle.d1;
  assign DmemREB         = r_bundle.reb;
  assign DmemWEB         = r_bundle.web;
  assign LoadStoremuxsel = r_bundle.lsm;
  assign mux2sel         = 1'b0;
  assign ex_illegal      = r_bundle.ill;

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Self-checking bench for id_ex_ctrl_pipe: vector table through a scoreboard, then hand-written
// sequences for load-use, MUL/DIV countdown, flush, backpressure and asynchronous reset.
module tb_id_ex_ctrl_pipe;

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] IMM = 7'b0010011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] F0  = 7'b0000000;
  localparam logic [6:0] FA  = 7'b0100000;
  localparam logic [6:0] FM  = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid, flush, ex_ready;
  logic [6:0] id_opcode, id_funct7;
  logic [2:0] id_funct3;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic       id_ready, ex_valid, ALUSourceA, Dmem1ALUOUT, DmemREB, DmemWEB;
  logic       LoadStoremuxsel, mux2sel, ex_illegal, muldiv_busy;
  logic [4:0] ex_rd;
  logic [3:0] ALUControl;
  logic [1:0] ALUSourceB;

  logic       d2_id_ready, d2_ex_valid, d2_srca, d2_d1, d2_reb, d2_web, d2_lsm, d2_mux2;
  logic       d2_ex_illegal, d2_busy;
  logic [4:0] d2_ex_rd;
  logic [3:0] d2_alu;
  logic [1:0] d2_srcb;

  id_ex_ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ALUControl(ALUControl), .ALUSourceA(ALUSourceA),
    .ALUSourceB(ALUSourceB), .Dmem1ALUOUT(Dmem1ALUOUT), .DmemREB(DmemREB),
    .DmemWEB(DmemWEB), .LoadStoremuxsel(LoadStoremuxsel), .mux2sel(mux2sel),
    .ex_illegal(ex_illegal), .muldiv_busy(muldiv_busy)
  );

  id_ex_ctrl_pipe #(.HAS_MULDIV(1'b0), .MULDIV_LAT(4), .REG_W(5)) dut_nomd (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(d2_id_ready),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(d2_ex_valid), .ex_rd(d2_ex_rd), .ALUControl(d2_alu), .ALUSourceA(d2_srca),
    .ALUSourceB(d2_srcb), .Dmem1ALUOUT(d2_d1), .DmemREB(d2_reb), .DmemWEB(d2_web),
    .LoadStoremuxsel(d2_lsm), .mux2sel(d2_mux2), .ex_illegal(d2_ex_illegal),
    .muldiv_busy(d2_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rs1, rs2, rd;
    logic [3:0] alu;
    logic [1:0] srcb;
    logic       d1, reb, web, lsm, ill;
    logic [4:0] erd;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  vec_t q[$];
  vec_t cur;
  vec_t tbl[18];

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [3:0] alu, input logic [1:0] srcb, input logic d1,
                              input logic reb, input logic web, input logic lsm, input logic ill,
                              input logic [4:0] erd);
    vec_t v;
    v = '{op: op, f3: f3, f7: f7, rs1: rs1, rs2: rs2, rd: rd, alu: alu, srcb: srcb,
          d1: d1, reb: reb, web: web, lsm: lsm, ill: ill, erd: erd};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    cur       = v;
    id_valid  = 1'b1;
    id_opcode = v.op;
    id_funct3 = v.f3;
    id_funct7 = v.f7;
    id_rs1    = v.rs1;
    id_rs2    = v.rs2;
    id_rd     = v.rd;
  endtask

  task automatic cmp_front();
    vec_t e;
    if (q.size() == 0) begin
      chk("unexpected_ex_valid", 32'(ex_valid), 32'd0);
    end else begin
      e = q[0];
      chk("ALUControl", 32'(ALUControl), 32'(e.alu));
      chk("ALUSourceB", 32'(ALUSourceB), 32'(e.srcb));
      chk("Dmem1ALUOUT", 32'(Dmem1ALUOUT), 32'(e.d1));
      chk("DmemREB", 32'(DmemREB), 32'(e.reb));
      chk("DmemWEB", 32'(DmemWEB), 32'(e.web));
      chk("LoadStoremuxsel", 32'(LoadStoremuxsel), 32'(e.lsm));
      chk("ex_illegal", 32'(ex_illegal), 32'(e.ill));
      chk("ex_rd", 32'(ex_rd), 32'(e.erd));
      chk("ALUSourceA", 32'(ALUSourceA), 32'd0);
      chk("mux2sel", 32'(mux2sel), 32'd0);
      chk("busy_with_valid", 32'(muldiv_busy), 32'd0);
    end
  endtask

  // Called just after a falling edge with inputs already driven
  task automatic tick();
    #1;
    if (flush) begin
      q.delete();
    end else begin
      if (ex_valid && ex_ready && q.size() > 0) void'(q.pop_front());
      if (id_valid && id_ready) q.push_back(cur);
    end
    @(posedge clk);
    @(negedge clk);
    if (ex_valid) cmp_front();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ex_valid"}, 32'(ex_valid), 32'd0);
    chk({tag, "_busy"}, 32'(muldiv_busy), 32'd0);
    chk({tag, "_illegal"}, 32'(ex_illegal), 32'd0);
    chk({tag, "_ex_rd"}, 32'(ex_rd), 32'd0);
    chk({tag, "_alu"}, 32'(ALUControl), 32'h2);
    chk({tag, "_srcb"}, 32'(ALUSourceB), 32'd0);
    chk({tag, "_reb"}, 32'(DmemREB), 32'd1);
    chk({tag, "_web"}, 32'(DmemWEB), 32'd1);
    chk({tag, "_d1"}, 32'(Dmem1ALUOUT), 32'd0);
    chk({tag, "_lsm"}, 32'(LoadStoremuxsel), 32'd0);
    chk({tag, "_srca"}, 32'(ALUSourceA), 32'd0);
    chk({tag, "_mux2sel"}, 32'(mux2sel), 32'd0);
  endtask

  task automatic do_reset();
    id_valid = 1'b0;
    flush    = 1'b0;
    ex_ready = 1'b1;
    rst_n    = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    id_opcode = '0; id_funct3 = '0; id_funct7 = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    chk("reset_id_ready", 32'(id_ready), 32'd1);
    rst_n = 1'b1;

    //            op   f3      f7  rs1 rs2 rd  alu      B      d1 reb web lsm ill erd
    tbl[0]  = mk(OP,  3'b000, F0, 1,  2,  3,  4'b0010, 2'b00, 0, 1, 1, 0, 0, 3);
    tbl[1]  = mk(OP,  3'b000, FA, 1,  2,  4,  4'b0110, 2'b00, 0, 1, 1, 0, 0, 4);
    tbl[2]  = mk(OP,  3'b101, FA, 1,  2,  5,  4'b1001, 2'b00, 0, 1, 1, 0, 0, 5);
    tbl[3]  = mk(OP,  3'b011, F0, 1,  2,  6,  4'b0011, 2'b00, 0, 1, 1, 0, 0, 6);
    tbl[4]  = mk(OP,  3'b111, F0, 1,  2,  7,  4'b0000, 2'b00, 0, 1, 1, 0, 0, 7);
    tbl[5]  = mk(OP,  3'b110, F0, 1,  2,  8,  4'b0001, 2'b00, 0, 1, 1, 0, 0, 8);
    tbl[6]  = mk(OP,  3'b100, F0, 1,  2,  9,  4'b0100, 2'b00, 0, 1, 1, 0, 0, 9);
    tbl[7]  = mk(OP,  3'b001, F0, 1,  2,  10, 4'b0101, 2'b00, 0, 1, 1, 0, 0, 10);
    tbl[8]  = mk(OP,  3'b010, F0, 1,  2,  11, 4'b0111, 2'b00, 0, 1, 1, 0, 0, 11);
    tbl[9]  = mk(OP,  3'b101, F0, 1,  2,  12, 4'b1000, 2'b00, 0, 1, 1, 0, 0, 12);
    tbl[10] = mk(IMM, 3'b101, FA, 1,  0,  13, 4'b1001, 2'b10, 0, 1, 1, 0, 0, 13);
    tbl[11] = mk(IMM, 3'b000, F0, 1,  0,  14, 4'b0010, 2'b10, 0, 1, 1, 0, 0, 14);
    tbl[12] = mk(IMM, 3'b001, F0, 1,  0,  15, 4'b0101, 2'b10, 0, 1, 1, 0, 0, 15);
    tbl[13] = mk(LD,  3'b010, F0, 1,  0,  7,  4'b0010, 2'b11, 1, 0, 1, 0, 0, 7);
    tbl[14] = mk(ST,  3'b010, F0, 2,  3,  0,  4'b0010, 2'b11, 1, 1, 0, 1, 0, 0);
    tbl[15] = mk(OP,  3'b001, FA, 0,  0,  16, 4'b0010, 2'b00, 0, 1, 1, 0, 1, 0);
    tbl[16] = mk(7'b1111111, 3'b000, F0, 0, 0, 17, 4'b0010, 2'b00, 0, 1, 1, 0, 1, 0);
    tbl[17] = mk(LD,  3'b000, F0, 0,  0,  18, 4'b0010, 2'b00, 0, 1, 1, 0, 1, 0);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i]);
      #1 chk("table_id_ready", 32'(id_ready), 32'd1);
      tick();
      chk("table_ex_valid", 32'(ex_valid), 32'd1);
    end
    id_valid = 1'b0;
    repeat (2) tick();

    // Load-use on rs1: one bubble, then the dependent ADD
    drive(mk(LD, 3'b010, F0, 1, 0, 5, 4'b0010, 2'b11, 1, 0, 1, 0, 0, 5));
    tick();
    drive(mk(OP, 3'b000, F0, 5, 1, 6, 4'b0010, 2'b00, 0, 1, 1, 0, 0, 6));
    #1 chk("lu_rs1_stall_ready", 32'(id_ready), 32'd0);
    tick();
    chk("lu_rs1_bubble", 32'(ex_valid), 32'd0);
    #1 chk("lu_rs1_ready_after", 32'(id_ready), 32'd1);
    tick();
    chk("lu_rs1_add_valid", 32'(ex_valid), 32'd1);

    // Load-use through a store's rs2
    drive(mk(LD, 3'b010, F0, 1, 0, 5, 4'b0010, 2'b11, 1, 0, 1, 0, 0, 5));
    tick();
    drive(mk(ST, 3'b010, F0, 1, 5, 0, 4'b0010, 2'b11, 1, 1, 0, 1, 0, 0));
    #1 chk("lu_rs2_stall_ready", 32'(id_ready), 32'd0);
    tick();
    chk("lu_rs2_bubble", 32'(ex_valid), 32'd0);
    tick();
    chk("lu_rs2_sw_valid", 32'(ex_valid), 32'd1);

    // OP-IMM does not read rs2, and rd=x0 never stalls
    drive(mk(LD, 3'b010, F0, 1, 0, 5, 4'b0010, 2'b11, 1, 0, 1, 0, 0, 5));
    tick();
    drive(mk(IMM, 3'b000, F0, 2, 5, 8, 4'b0010, 2'b10, 0, 1, 1, 0, 0, 8));
    #1 chk("imm_rs2_no_stall", 32'(id_ready), 32'd1);
    tick();
    drive(mk(LD, 3'b010, F0, 1, 0, 0, 4'b0010, 2'b11, 1, 0, 1, 0, 0, 0));
    tick();
    drive(mk(OP, 3'b000, F0, 0, 0, 6, 4'b0010, 2'b00, 0, 1, 1, 0, 0, 6));
    #1 chk("x0_no_stall", 32'(id_ready), 32'd1);
    tick();
    chk("x0_add_valid", 32'(ex_valid), 32'd1);
    id_valid = 1'b0;
    tick();

    // MUL: three busy cycles, valid on the fourth; no-M variant flags it illegal at once
    do_reset();
    drive(mk(OP, 3'b000, FM, 1, 2, 9, 4'b1010, 2'b00, 0, 1, 1, 0, 0, 9));
    tick();
    chk("nomd_ex_valid", 32'(d2_ex_valid), 32'd1);
    chk("nomd_illegal", 32'(d2_ex_illegal), 32'd1);
    chk("nomd_alu", 32'(d2_alu), 32'h2);
    chk("nomd_busy", 32'(d2_busy), 32'd0);
    chk("mul_busy_0", 32'(muldiv_busy), 32'd1);
    chk("mul_valid_0", 32'(ex_valid), 32'd0);
    drive(mk(OP, 3'b000, F0, 1, 2, 11, 4'b0010, 2'b00, 0, 1, 1, 0, 0, 11));
    #1 chk("mul_ready_0", 32'(id_ready), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("mul_busy_n", 32'(muldiv_busy), 32'd1);
      chk("mul_valid_n", 32'(ex_valid), 32'd0);
      #1 chk("mul_ready_n", 32'(id_ready), 32'd0);
    end
    tick();
    chk("mul_done_busy", 32'(muldiv_busy), 32'd0);
    chk("mul_done_valid", 32'(ex_valid), 32'd1);
    #1 chk("mul_done_ready", 32'(id_ready), 32'd1);
    tick();
    chk("after_mul_add_valid", 32'(ex_valid), 32'd1);
    id_valid = 1'b0;
    tick();

    // Flush mid-countdown kills the DIV; next instruction is accepted
    drive(mk(OP, 3'b100, FM, 1, 2, 10, 4'b1011, 2'b00, 0, 1, 1, 0, 0, 10));
    tick();
    chk("div_busy", 32'(muldiv_busy), 32'd1);
    drive(mk(OP, 3'b000, F0, 1, 2, 12, 4'b0010, 2'b00, 0, 1, 1, 0, 0, 12));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_busy", 32'(muldiv_busy), 32'd0);
    chk("flush_alu", 32'(ALUControl), 32'h2);
    chk("flush_rd", 32'(ex_rd), 32'd0);
    #1 chk("flush_ready", 32'(id_ready), 32'd1);
    tick();
    chk("flush_next_valid", 32'(ex_valid), 32'd1);
    id_valid = 1'b0;
    repeat (5) tick();

    // SW held under backpressure, then asynchronous reset mid-hold
    drive(mk(ST, 3'b010, F0, 1, 2, 0, 4'b0010, 2'b11, 1, 1, 0, 1, 0, 0));
    tick();
    id_valid = 1'b0;
    ex_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_valid", 32'(ex_valid), 32'd1);
      chk("bp_web", 32'(DmemWEB), 32'd0);
      chk("bp_lsm", 32'(LoadStoremuxsel), 32'd1);
    end
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ex_ready = 1'b1;

    // Reset during a MUL countdown leaves no pending completion
    drive(mk(OP, 3'b001, FM, 1, 2, 13, 4'b1010, 2'b00, 0, 1, 1, 0, 0, 13));
    tick();
    id_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("rst_mul_busy", 32'(muldiv_busy), 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("rst_mul_no_valid", 32'(ex_valid), 32'd0);

    drive(mk(OP, 3'b000, FA, 3, 4, 20, 4'b0110, 2'b00, 0, 1, 1, 0, 0, 20));
    tick();
    chk("post_reset_sub_valid", 32'(ex_valid), 32'd1);
    id_valid = 1'b0;
    tick();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
